// File: rtl/plab5_mcore_mem_req_cmsg_unpack_queue_pkg.sv
// plab5_mcore_mem_req_cmsg_unpack_queue_pkg: mem-request control message types and field layout
// Layout of a packed message, MSB first: type | opaque | addr | len
package plab5_mcore_mem_req_cmsg_unpack_queue_pkg;

    localparam int TYPE_NBITS = 3;

    localparam logic [TYPE_NBITS-1:0] TYPE_READ  = 3'd0;
    localparam logic [TYPE_NBITS-1:0] TYPE_WRITE = 3'd1;
    localparam logic [TYPE_NBITS-1:0] TYPE_INIT  = 3'd2;

    function automatic int len_nbits(int d);
        return $clog2(d / 8);
    endfunction

    function automatic int opaque_lsb(int a, int d);
        return len_nbits(d) + a;
    endfunction

    function automatic int type_lsb(int o, int a, int d);
        return len_nbits(d) + a + o;
    endfunction

    function automatic int msg_nbits(int o, int a, int d);
        return type_lsb(o, a, d) + TYPE_NBITS;
    endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_cmsg_unpack.sv
// plab5_mcore_mem_req_cmsg_unpack: combinational field slicer for a packed mem-request control message
// Ports: msg (packed message) -> msg_type, opaque, addr, len
module plab5_mcore_mem_req_cmsg_unpack
    import plab5_mcore_mem_req_cmsg_unpack_queue_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    localparam int l = len_nbits(p_data_nbits),
    localparam int c = msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)
) (
    input  logic [c-1:0]              msg,
    output logic [TYPE_NBITS-1:0]     msg_type,
    output logic [p_opaque_nbits-1:0] opaque,
    output logic [p_addr_nbits-1:0]   addr,
    output logic [l-1:0]              len
);

    assign msg_type = msg[c-1 -: TYPE_NBITS];
    assign opaque   = msg[opaque_lsb(p_addr_nbits, p_data_nbits) +: p_opaque_nbits];
    assign addr     = msg[l +: p_addr_nbits];
    assign len      = msg[l-1:0];

endmodule

// File: rtl/plab5_mcore_mem_req_cmsg_unpack_queue.sv
// plab5_mcore_mem_req_cmsg_unpack_queue: 2-entry FIFO of mem-request control messages with unpacked head
// Ports: clk, reset (sync, active-high); in_val/in_rdy/in_msg (packed input);
//        out_val/out_rdy and out_type/out_opaque/out_addr/out_len/out_nbytes (head entry);
//        out_count (occupancy); err_count (illegal-type drops, only with PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN)
// Optional feature macro: PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN drops and counts messages with type > INIT.
module plab5_mcore_mem_req_cmsg_unpack_queue
    import plab5_mcore_mem_req_cmsg_unpack_queue_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    localparam int l = len_nbits(p_data_nbits),
    localparam int c = msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [c-1:0]              in_msg,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [TYPE_NBITS-1:0]     out_type,
    output logic [p_opaque_nbits-1:0] out_opaque,
    output logic [p_addr_nbits-1:0]   out_addr,
    output logic [l-1:0]              out_len,
    output logic [l:0]                out_nbytes,
`ifdef PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN
    output logic [7:0]                err_count,
`endif
    output logic [1:0]                out_count
);

    logic [c-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   count;
    logic         acc;
    logic         enq;
    logic         deq;

    // Ready/valid come only from the registered count, so there is no in->out combinational path.
    assign in_rdy    = count != 2'd2;
    assign out_val   = count != 2'd0;
    assign out_count = count;
    assign acc       = in_val && in_rdy;
    assign deq       = out_val && out_rdy;

`ifdef PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN
    logic bad;
    // Illegal types are still handshaken so the producer is never stalled by them.
    assign bad = in_msg[c-1 -: TYPE_NBITS] > TYPE_INIT;
    assign enq = acc && !bad;
    always_ff @(posedge clk)
        if (reset)
            err_count <= 8'd0;
        else if (acc && bad && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
`else
    assign enq = acc;
`endif

    always_ff @(posedge clk)
        if (reset) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (enq) wptr <= ~wptr;
            if (deq) rptr <= ~rptr;
            count <= count + {1'b0, enq} - {1'b0, deq};
        end

    // Storage is not reset; a stray write during reset is harmless since the pointers restart.
    always_ff @(posedge clk)
        if (enq) mem[wptr] <= in_msg;

    plab5_mcore_mem_req_cmsg_unpack #(
        .p_opaque_nbits(p_opaque_nbits),
        .p_addr_nbits  (p_addr_nbits),
        .p_data_nbits  (p_data_nbits)
    ) u_unpack (
        .msg     (mem[rptr]),
        .msg_type(out_type),
        .opaque  (out_opaque),
        .addr    (out_addr),
        .len     (out_len)
    );

    // len 0 encodes a full data word.
    assign out_nbytes = (out_len == '0) ? (l+1)'(p_data_nbits / 8) : {1'b0, out_len};

endmodule

// File: tb/tb_plab5_mcore_mem_req_cmsg_unpack_queue.sv
// tb_plab5_mcore_mem_req_cmsg_unpack_queue: scoreboard bench for the mem-request cmsg unpack queue
module tb_plab5_mcore_mem_req_cmsg_unpack_queue;

    typedef struct {
        logic [2:0]  t;
        logic [7:0]  o;
        logic [31:0] a;
        logic [1:0]  l;
    } exp_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        in_val = 0;
    logic        in_rdy;
    logic [44:0] in_msg = '0;
    logic        out_val;
    logic        out_rdy = 0;
    logic [2:0]  out_type;
    logic [7:0]  out_opaque;
    logic [31:0] out_addr;
    logic [1:0]  out_len;
    logic [2:0]  out_nbytes;
    logic [1:0]  out_count;
`ifdef PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN
    logic [7:0]  err_count;
`endif

    int   vecs = 0;
    int   errs = 0;
    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    plab5_mcore_mem_req_cmsg_unpack_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_msg    (in_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_type  (out_type),
        .out_opaque(out_opaque),
        .out_addr  (out_addr),
        .out_len   (out_len),
        .out_nbytes(out_nbytes),
`ifdef PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN
        .err_count (err_count),
`endif
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a, input logic [1:0] l);
        in_val = 1;
        in_msg = {t, o, a, l};
        cur = '{t: t, o: o, a: a, l: l};
    endtask

    // Monitor on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (out_val && out_rdy) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_type", out_type, e.t);
                    chk("out_opaque", out_opaque, e.o);
                    chk("out_addr", out_addr, e.a);
                    chk("out_len", out_len, e.l);
                    chk("out_nbytes", out_nbytes, (e.l == 0) ? 3'd4 : {1'b0, e.l});
                end
            end
`ifdef PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN
            if (in_val && in_rdy && cur.t <= 3'd2) sb.push_back(cur);
`else
            if (in_val && in_rdy) sb.push_back(cur);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        step();
        step();
        reset = 0;
        chk("rst_out_val", out_val, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_count", out_count, 0);
`ifdef PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN
        chk("rst_err", err_count, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_out_val", out_val, 0);
            chk("idle_count", out_count, 0);
            chk("idle_in_rdy", in_rdy, 1);
        end

        out_rdy = 1;
        drive(3'd1, 8'h5A, 32'h0000_1000, 2'd0);
        step();
        in_val = 0;
        chk("single_out_val", out_val, 1);
        chk("single_nbytes", out_nbytes, 4);
        chk("single_type", out_type, 1);
        step();
        chk("single_drained", out_val, 0);

        out_rdy = 0;
        drive(3'd0, 8'h01, 32'hA000_0000, 2'd1);
        step();
        chk("fill_count1", out_count, 1);
        drive(3'd1, 8'h02, 32'hA000_0004, 2'd2);
        step();
        chk("fill_count2", out_count, 2);
        chk("fill_in_rdy", in_rdy, 0);
        drive(3'd2, 8'h03, 32'hA000_0008, 2'd3);
        step();
        chk("stall_count", out_count, 2);
        out_rdy = 1;
        step();
        chk("drain_count1", out_count, 1);
        chk("drain_in_rdy", in_rdy, 1);
        step();
        chk("third_acc_count", out_count, 1);
        in_val = 0;
        step();
        chk("drain_empty", out_count, 0);

        for (int i = 0; i < 16; i++) begin
            drive(3'(i % 3), 8'($urandom), $urandom, (i % 2 == 0) ? 2'd3 : 2'(i % 4));
            step();
            chk("stream_count", out_count, 1);
            chk("stream_out_val", out_val, 1);
        end
        in_val = 0;
        step();
        chk("stream_empty", out_count, 0);

        out_rdy = 0;
        drive(3'd0, 8'hAA, 32'hDEAD_0000, 2'd0);
        step();
        drive(3'd1, 8'hBB, 32'hDEAD_0004, 2'd1);
        step();
        chk("pre_rst_count", out_count, 2);
        reset = 1;
        out_rdy = 1;
        drive(3'd2, 8'hCC, 32'hDEAD_0008, 2'd2);
        step();
        sb.delete();
        reset = 0;
        in_val = 0;
        chk("mid_rst_out_val", out_val, 0);
        chk("mid_rst_count", out_count, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale", out_val, 0);
        end

`ifdef PLAB5_MCORE_MEMREQ_TYPE_CHECK_EN
        drive(3'd5, 8'h55, 32'h0000_5000, 2'd1);
        step();
        chk("illegal_not_enq", out_count, 0);
        chk("illegal_err", err_count, 1);
        drive(3'd0, 8'h66, 32'h0000_6000, 2'd2);
        step();
        in_val = 0;
        chk("legal_enq", out_count, 1);
        step();
        chk("err_final", err_count, 1);
`else
        drive(3'd7, 8'h77, 32'h0000_7000, 2'd3);
        step();
        in_val = 0;
        chk("type7_enq", out_count, 1);
        chk("type7_pass", out_type, 7);
        step();
`endif
        chk("sb_drained", sb.size(), 0);
        chk("final_empty", out_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
